branch_sequencer: RTL
=====================

BRANCH_SEQUENCER -- requirements
Module: branch_sequencer

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the PC value loaded at reset.
REQ-002 The block SHALL have parameter FLUSH_CYCLES, default 1, range 1..7, meaning the bubble cycles inserted after a redirect.
REQ-003 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port stall, input, 1, meaning hold PC and ignore the branch decision this cycle.
REQ-006 The block SHALL have port operacion, input, 4, the comparison code driven to the branch unit this cycle.
REQ-007 The block SHALL have port resultado, input, 1, the branch unit decision for operacion.
REQ-008 The block SHALL have port target, input, 32, the branch/jump destination address.
REQ-009 The block SHALL have port pc, output, 32, the registered current fetch address.
REQ-010 The block SHALL have port flush, output, 1, registered; kills younger instructions while high.
REQ-011 The block SHALL have port misalign, output, 1, registered sticky trap flag.
REQ-012 The block SHALL have port cnt_total, output, 16, evaluated control-transfer count.
REQ-013 The block SHALL have port cnt_taken, output, 16, taken control-transfer count.

Function
REQ-014 The block SHALL treat an operation as evaluated only when operacion is one of 1000, 1001, 1100, 1101, 1111, state is RUN and stall=0; all other codes are sequential.
REQ-015 The block SHALL implement three states: RUN, FLUSH, TRAP.
REQ-016 In RUN, when stall=1, pc, counters and state SHALL hold; stall wins over a simultaneous taken decision.
REQ-017 In RUN, for a non-evaluated or not-taken cycle with stall=0, pc SHALL become pc+4 (32-bit wrap, FFFF_FFFC -> 0000_0000) at the next edge.
REQ-018 In RUN, for an evaluated cycle with resultado=1 and target[1:0]=00, the next edge SHALL load pc=target, set flush=1, load the bubble counter with FLUSH_CYCLES and enter FLUSH.
REQ-019 In RUN, for an evaluated taken cycle with target[1:0]!=00, the next edge SHALL hold pc, set misalign=1, flush=1, and enter TRAP.
REQ-020 In FLUSH, pc SHALL hold, stall and branch inputs SHALL be ignored, and the counter SHALL decrement each cycle; flush SHALL be high for exactly FLUSH_CYCLES cycles, and the block SHALL return to RUN with flush=0.
REQ-021 TRAP SHALL be exited only by reset; pc, counters held; misalign=1, flush=1.
REQ-022 cnt_total SHALL increment by 1 per evaluated cycle; cnt_taken by 1 per evaluated cycle with resultado=1, including 1111 and the misaligned case; both saturate at 16'hFFFF.
REQ-023 resultado for a code outside REQ-014 SHALL be ignored.

Reset
REQ-024 On rst_n=0, asynchronously: pc=RESET_PC, state=RUN, flush=0, misalign=0, cnt_total=0, cnt_taken=0, bubble counter=0.
REQ-025 Reset asserted mid-FLUSH or in TRAP SHALL abort immediately to the REQ-024 values; the first edge after release behaves as RUN.

Structure
REQ-026 Package br_pkg SHALL hold the branch-code constants (BR_EQ=1000, BR_NE=1001, BR_LT=1100, BR_GE=1101, BR_JMP=1111), the state enum, and the 16-bit counter width.
REQ-027 The block SHALL use one sub-module, sat_counter (parameterised width, inc and clear inputs, saturating), instantiated twice for the counters.
REQ-028 The block SHALL not instantiate the branch unit; resultado arrives from it.

Verification
REQ-029 The bench SHALL cover reset release then 3 cycles operacion=0000 -> pc 0,4,8,C; flush=0; counters 0.
REQ-030 The bench SHALL cover, at pc=8, operacion=1000, resultado=1, target=0x100 -> next pc=0x100, flush=1 one cycle (FLUSH_CYCLES=1), then pc=0x104; cnt_total=1, cnt_taken=1.
REQ-031 The bench SHALL cover operacion=1100, resultado=1, stall=1 for 2 cycles, then stall=0 -> pc held 2 cycles, redirect on the third; counters increment once.
REQ-032 The bench SHALL cover operacion=1111, target=0x102 -> misalign=1, flush=1, pc unchanged; further stimulus ignored until rst_n=0, after which pc=RESET_PC.
REQ-033 The bench SHALL cover FLUSH_CYCLES=3 with taken 1001 followed by a taken 1000 during FLUSH -> second ignored, flush high exactly 3 cycles, cnt_taken=1.
REQ-034 The bench SHALL cover cnt_total preloaded to FFFE via 0xFFFE evaluated not-taken 1101 ops, then 3 more -> cnt_total=FFFF, cnt_taken=0.

Source files
------------

// File: rtl/br_pkg.sv
// Shared definitions for the branch sequencer: branch codes, FSM states and
// counter width.
package br_pkg;

  localparam int CNT_W = 16;

  localparam logic [3:0] BR_EQ  = 4'b1000;
  localparam logic [3:0] BR_NE  = 4'b1001;
  localparam logic [3:0] BR_LT  = 4'b1100;
  localparam logic [3:0] BR_GE  = 4'b1101;
  localparam logic [3:0] BR_JMP = 4'b1111;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_FLUSH = 2'd1,
    ST_TRAP  = 2'd2
  } state_e;

  function automatic logic is_branch(input logic [3:0] op);
    return (op == BR_EQ) || (op == BR_NE) || (op == BR_LT) ||
           (op == BR_GE) || (op == BR_JMP);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clear,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clear) begin
      count_q <= '0;
    end else if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_sequencer.sv
// Fetch-PC sequencer: advances the PC, redirects on taken branches with a
// bubble window, and traps (sticky until reset) on misaligned targets.
//
// state    | meaning
// ST_RUN   | normal fetch, branch decisions evaluated
// ST_FLUSH | post-redirect bubbles, inputs ignored, pc held
// ST_TRAP  | misaligned target seen, frozen until reset
module branch_sequencer
  import br_pkg::*;
#(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          FLUSH_CYCLES = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic [3:0]       operacion,
  input  logic             resultado,
  input  logic [31:0]      target,
  output logic [31:0]      pc,
  output logic             flush,
  output logic             misalign,
  output logic [CNT_W-1:0] cnt_total,
  output logic [CNT_W-1:0] cnt_taken
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        flush_q, flush_d;
  logic        misalign_q, misalign_d;
  logic [2:0]  bub_q, bub_d;
  logic        evaluated;
  logic        taken;

  assign evaluated = (state_q == ST_RUN) && !stall && is_branch(operacion);
  assign taken     = evaluated && resultado;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      flush_q    <= 1'b0;
      misalign_q <= 1'b0;
      bub_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      flush_q    <= flush_d;
      misalign_q <= misalign_d;
      bub_q      <= bub_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    flush_d    = flush_q;
    misalign_d = misalign_q;
    bub_d      = bub_q;
    case (state_q)
      ST_RUN: begin
        if (!stall) begin
          if (taken) begin
            flush_d = 1'b1;
            if (target[1:0] == 2'b00) begin
              pc_d    = target;
              bub_d   = 3'(FLUSH_CYCLES);
              state_d = ST_FLUSH;
            end else begin
              misalign_d = 1'b1;
              state_d    = ST_TRAP;
            end
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
      end
      ST_FLUSH: begin
        // Last bubble: flush drops on the same edge that returns to RUN.
        if (bub_q <= 3'd1) begin
          bub_d   = 3'd0;
          flush_d = 1'b0;
          state_d = ST_RUN;
        end else begin
          bub_d = bub_q - 3'd1;
        end
      end
      ST_TRAP: begin
        flush_d    = 1'b1;
        misalign_d = 1'b1;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  sat_counter #(.WIDTH(CNT_W)) u_cnt_total (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (evaluated),
    .clear (1'b0),
    .count (cnt_total)
  );

  sat_counter #(.WIDTH(CNT_W)) u_cnt_taken (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (taken),
    .clear (1'b0),
    .count (cnt_taken)
  );

  assign pc       = pc_q;
  assign flush    = flush_q;
  assign misalign = misalign_q;

endmodule
